// File: rtl/ctrl_pkg.sv
// Shared stage encodings, instruction-class encodings and the control-word layout.
// Latency: n/a (declarations and one pure helper function).
// Backpressure: n/a.
package ctrl_pkg;

    localparam logic [1:0] ST_LOAD    = 2'b00;
    localparam logic [1:0] ST_FETCH   = 2'b01;
    localparam logic [1:0] ST_DECODE  = 2'b10;
    localparam logic [1:0] ST_EXECUTE = 2'b11;

    // ALU-memory ops are split into load and store because the store is the
    // only class that waits in EXECUTE.
    typedef enum logic [2:0] {
        CLS_NOP     = 3'd0,
        CLS_JMP     = 3'd1,
        CLS_ALU_ST  = 3'd2,
        CLS_ALU_LD  = 3'd3,
        CLS_CJMP    = 3'd4,
        CLS_ALU_IMM = 3'd5
    } op_cls_t;

    typedef struct packed {
        logic pc_e;
        logic acc_e;
        logic sr_e;
        logic ir_e;
        logic dr_e;
        logic pmem_e;
        logic dmem_e;
        logic dmem_we;
        logic alu_e;
        logic mux1_sel;
        logic mux2_sel;
        logic pmem_le;
    } ctrl_t;

    function automatic op_cls_t op_class(input logic [3:0] op);
        if (op[3])
            return CLS_ALU_IMM;
        else if (op[2])
            return CLS_CJMP;
        else if (op[1])
            return op[0] ? CLS_ALU_LD : CLS_ALU_ST;
        else if (op[0])
            return CLS_JMP;
        else
            return CLS_NOP;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control-word and next-stage decode for the control sequencer.
// Latency: zero cycles, pure combinational.
// Backpressure: dmem_ready low holds the stage for memory classes; run low holds FETCH.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int IR_W   = 12,
    parameter int SR_W   = 4,
    parameter int MODE_W = 4
) (
    input  logic [1:0]        stage,
    input  logic [IR_W-1:0]   ir,
    input  logic [SR_W-1:0]   sr,
    input  logic              dmem_ready,
    input  logic              run,
    input  logic              load_last,
    input  op_cls_t           cls,
    output ctrl_t             ctl,
    output logic [MODE_W-1:0] alu_mode,
    output logic [1:0]        stage_nxt
);

    // Opcode and low operand bits are consumed through cls or not at all.
    logic in_unused;
    assign in_unused = ^{ir, sr};

    // Per-stage control word and successor stage; everything defaults to idle.
    always_comb begin
        ctl       = '0;
        alu_mode  = '0;
        stage_nxt = stage;
        case (stage)
            ST_LOAD: begin
                ctl.pmem_le = 1'b1;
                ctl.pmem_e  = 1'b1;
                if (load_last)
                    stage_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (run) begin
                    ctl.ir_e   = 1'b1;
                    ctl.pmem_e = 1'b1;
                    stage_nxt  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (cls == CLS_ALU_LD || cls == CLS_ALU_ST) begin
                    ctl.dr_e   = 1'b1;
                    ctl.dmem_e = 1'b1;
                    if (dmem_ready)
                        stage_nxt = ST_EXECUTE;
                end else begin
                    stage_nxt = ST_EXECUTE;
                end
            end
            default: begin
                stage_nxt = ST_FETCH;
                case (cls)
                    CLS_ALU_IMM: begin
                        ctl.pc_e     = 1'b1;
                        ctl.acc_e    = 1'b1;
                        ctl.sr_e     = 1'b1;
                        ctl.alu_e    = 1'b1;
                        ctl.mux1_sel = 1'b1;
                        alu_mode     = MODE_W'(ir[IR_W-2:IR_W-4]);
                    end
                    CLS_CJMP: begin
                        ctl.pc_e     = 1'b1;
                        ctl.mux1_sel = sr[ir[IR_W-3:IR_W-4]];
                    end
                    CLS_ALU_LD: begin
                        ctl.pc_e     = 1'b1;
                        ctl.acc_e    = 1'b1;
                        ctl.sr_e     = 1'b1;
                        ctl.alu_e    = 1'b1;
                        ctl.mux1_sel = 1'b1;
                        ctl.mux2_sel = 1'b1;
                        alu_mode     = ir[IR_W-5 -: MODE_W];
                    end
                    CLS_ALU_ST: begin
                        ctl.dmem_e   = 1'b1;
                        ctl.dmem_we  = 1'b1;
                        ctl.alu_e    = 1'b1;
                        ctl.mux1_sel = 1'b1;
                        ctl.mux2_sel = 1'b1;
                        alu_mode     = ir[IR_W-5 -: MODE_W];
                        // PC and flags advance only once the write lands.
                        if (dmem_ready) begin
                            ctl.pc_e = 1'b1;
                            ctl.sr_e = 1'b1;
                        end else begin
                            stage_nxt = ST_EXECUTE;
                        end
                    end
                    CLS_JMP: begin
                        ctl.pc_e     = 1'b1;
                        ctl.mux1_sel = 1'b0;
                    end
                    default: begin
                        ctl.pc_e     = 1'b1;
                        ctl.mux1_sel = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Four-stage LOAD/FETCH/DECODE/EXECUTE control sequencer with program-load counter.
// Latency: one cycle per stage; enables are combinational from the current stage.
// Backpressure: run low parks in FETCH; dmem_ready low stretches memory DECODE/EXECUTE.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int IR_W       = 12,
    parameter int SR_W       = 4,
    parameter int LOAD_DEPTH = 256,
    parameter int MODE_W     = 4,
    parameter int AW         = (LOAD_DEPTH > 1) ? $clog2(LOAD_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IR_W-1:0]   ir,
    input  logic [SR_W-1:0]   sr,
    input  logic              dmem_ready,
    input  logic              run,
    output logic [1:0]        stage,
    output logic [AW-1:0]     load_addr,
    output logic              PC_E,
    output logic              Acc_E,
    output logic              SR_E,
    output logic              IR_E,
    output logic              DR_E,
    output logic              PMem_E,
    output logic              DMem_E,
    output logic              DMem_WE,
    output logic              ALU_E,
    output logic              MUX1_Sel,
    output logic              MUX2_Sel,
    output logic              PMem_LE,
    output logic [MODE_W-1:0] ALU_Mode
);

    logic [1:0] stage_nxt;
    logic       load_last;
    logic       hold_q;
    op_cls_t    cls_q;
    op_cls_t    path_cls;
    ctrl_t      ctl;

    assign load_last = (load_addr == AW'(LOAD_DEPTH - 1));

    // The class is taken from ir on the first DECODE cycle and then frozen,
    // so an ir change during a memory wait cannot redirect the sequence.
    assign path_cls = (stage == ST_DECODE && !hold_q) ? op_class(ir[IR_W-1 -: 4]) : cls_q;

    ctrl_decode #(
        .IR_W   (IR_W),
        .SR_W   (SR_W),
        .MODE_W (MODE_W)
    ) u_decode (
        .stage      (stage),
        .ir         (ir),
        .sr         (sr),
        .dmem_ready (dmem_ready),
        .run        (run),
        .load_last  (load_last),
        .cls        (path_cls),
        .ctl        (ctl),
        .alu_mode   (ALU_Mode),
        .stage_nxt  (stage_nxt)
    );

    // Stage register, load counter and frozen instruction class.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage     <= ST_LOAD;
            load_addr <= '0;
            hold_q    <= 1'b0;
            cls_q     <= CLS_NOP;
        end else begin
            stage  <= stage_nxt;
            cls_q  <= path_cls;
            hold_q <= (stage == ST_DECODE || stage == ST_EXECUTE) &&
                      (stage_nxt == ST_DECODE || stage_nxt == ST_EXECUTE);
            if (stage == ST_LOAD && !load_last)
                load_addr <= load_addr + 1'b1;
            else
                load_addr <= '0;
        end
    end

    assign PC_E     = ctl.pc_e;
    assign Acc_E    = ctl.acc_e;
    assign SR_E     = ctl.sr_e;
    assign IR_E     = ctl.ir_e;
    assign DR_E     = ctl.dr_e;
    assign PMem_E   = ctl.pmem_e;
    assign DMem_E   = ctl.dmem_e;
    assign DMem_WE  = ctl.dmem_we;
    assign ALU_E    = ctl.alu_e;
    assign MUX1_Sel = ctl.mux1_sel;
    assign MUX2_Sel = ctl.mux2_sel;
    assign PMem_LE  = ctl.pmem_le;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a four-word program load.
// Latency: inputs driven at falling edge + 1, outputs sampled before the next rising edge.
// Backpressure: dmem_ready and run are driven directly by the stimulus.
module tb_control_sequencer;

    logic        clk;
    logic        rst_n;
    logic [11:0] ir;
    logic [3:0]  sr;
    logic        dmem_ready;
    logic        run;
    logic [1:0]  stage;
    logic [1:0]  load_addr;
    logic        PC_E, Acc_E, SR_E, IR_E, DR_E, PMem_E, DMem_E, DMem_WE;
    logic        ALU_E, MUX1_Sel, MUX2_Sel, PMem_LE;
    logic [3:0]  ALU_Mode;
    logic [11:0] vec;

    int n_cmp;
    int n_bad;

    control_sequencer #(
        .IR_W       (12),
        .SR_W       (4),
        .LOAD_DEPTH (4),
        .MODE_W     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ir         (ir),
        .sr         (sr),
        .dmem_ready (dmem_ready),
        .run        (run),
        .stage      (stage),
        .load_addr  (load_addr),
        .PC_E       (PC_E),
        .Acc_E      (Acc_E),
        .SR_E       (SR_E),
        .IR_E       (IR_E),
        .DR_E       (DR_E),
        .PMem_E     (PMem_E),
        .DMem_E     (DMem_E),
        .DMem_WE    (DMem_WE),
        .ALU_E      (ALU_E),
        .MUX1_Sel   (MUX1_Sel),
        .MUX2_Sel   (MUX2_Sel),
        .PMem_LE    (PMem_LE),
        .ALU_Mode   (ALU_Mode)
    );

    // Enable vector, MSB first: PC Acc SR IR DR PMem DMem DMemWE ALU MUX1 MUX2 PMemLE
    assign vec = {PC_E, Acc_E, SR_E, IR_E, DR_E, PMem_E, DMem_E, DMem_WE,
                  ALU_E, MUX1_Sel, MUX2_Sel, PMem_LE};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one non-memory instruction from FETCH through EXECUTE and back.
    task automatic run_simple(input string tag, input logic [11:0] ir_v, input logic [3:0] sr_v,
                              input logic [11:0] exp_vec, input logic [3:0] exp_mode,
                              input bit chk_mode);
        ir  = ir_v;
        sr  = sr_v;
        run = 1'b1;
        #1;
        check_val({tag, "_fetch_vec"}, 32'(vec), 32'h140);
        @(negedge clk); #1;
        run = 1'b0;
        check_val({tag, "_dec_stage"}, 32'(stage), 32'd2);
        check_val({tag, "_dec_vec"}, 32'(vec), 32'h000);
        @(negedge clk); #1;
        check_val({tag, "_exe_stage"}, 32'(stage), 32'd3);
        check_val({tag, "_exe_vec"}, 32'(vec), 32'(exp_vec));
        if (chk_mode)
            check_val({tag, "_exe_mode"}, 32'(ALU_Mode), 32'(exp_mode));
        @(negedge clk); #1;
        check_val({tag, "_back_fetch"}, 32'(stage), 32'd1);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        run        = 1'b0;
        ir         = 12'h000;
        sr         = 4'h0;
        dmem_ready = 1'b0;
        #1;
        check_val("rst_stage", 32'(stage), 32'd0);
        check_val("rst_addr", 32'(load_addr), 32'd0);
        check_val("rst_vec", 32'(vec), 32'h041);

        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("load_stage", 32'(stage), 32'd0);
            check_val("load_addr", 32'(load_addr), 32'(i));
            check_val("load_vec", 32'(vec), 32'h041);
            @(negedge clk);
        end
        #1;
        check_val("post_load_stage", 32'(stage), 32'd1);
        check_val("post_load_addr", 32'(load_addr), 32'd0);

        // Parked in FETCH with run low.
        for (int i = 0; i < 5; i++) begin
            check_val("idle_stage", 32'(stage), 32'd1);
            check_val("idle_vec", 32'(vec), 32'h000);
            @(negedge clk); #1;
        end

        run_simple("alu_imm",   12'hA05, 4'b0000, 12'hE0C, 4'h2, 1'b1);
        run_simple("alu_imm7",  12'hF00, 4'b0000, 12'hE0C, 4'h7, 1'b1);
        run_simple("cjmp_take", 12'h600, 4'b0100, 12'h804, 4'h0, 1'b0);
        run_simple("cjmp_skip", 12'h600, 4'b0000, 12'h800, 4'h0, 1'b0);
        run_simple("jmp",       12'h100, 4'b1111, 12'h800, 4'h0, 1'b0);
        run_simple("nop",       12'h000, 4'b0000, 12'h804, 4'h0, 1'b0);

        // Store with three wait cycles in both DECODE and EXECUTE.
        ir = 12'h230; sr = 4'h0; dmem_ready = 1'b0; run = 1'b1;
        #1;
        check_val("st_fetch_vec", 32'(vec), 32'h140);
        @(negedge clk); #1;
        run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_val("st_dec_wait_stage", 32'(stage), 32'd2);
            check_val("st_dec_wait_vec", 32'(vec), 32'h0A0);
            @(negedge clk); #1;
        end
        dmem_ready = 1'b1; #1;
        check_val("st_dec_rdy_stage", 32'(stage), 32'd2);
        check_val("st_dec_rdy_vec", 32'(vec), 32'h0A0);
        @(negedge clk); #1;
        dmem_ready = 1'b0; #1;
        for (int k = 0; k < 3; k++) begin
            check_val("st_exe_wait_stage", 32'(stage), 32'd3);
            check_val("st_exe_wait_vec", 32'(vec), 32'h03E);
            check_val("st_exe_wait_mode", 32'(ALU_Mode), 32'h3);
            @(negedge clk); #1;
        end
        dmem_ready = 1'b1; #1;
        check_val("st_exe_rdy_stage", 32'(stage), 32'd3);
        check_val("st_exe_rdy_vec", 32'(vec), 32'hA3E);
        @(negedge clk); #1;
        dmem_ready = 1'b0;
        check_val("st_back_fetch", 32'(stage), 32'd1);

        // Load from memory, ready immediately.
        ir = 12'h330; dmem_ready = 1'b1; run = 1'b1;
        @(negedge clk); #1;
        run = 1'b0;
        check_val("ld_dec_vec", 32'(vec), 32'h0A0);
        @(negedge clk); #1;
        check_val("ld_exe_stage", 32'(stage), 32'd3);
        check_val("ld_exe_vec", 32'(vec), 32'hE0E);
        check_val("ld_exe_mode", 32'(ALU_Mode), 32'h3);
        @(negedge clk); #1;
        check_val("ld_back_fetch", 32'(stage), 32'd1);

        // Reset in the middle of a store wait in EXECUTE.
        ir = 12'h230; dmem_ready = 1'b1; run = 1'b1;
        @(negedge clk); #1;
        run = 1'b0;
        @(negedge clk); #1;
        dmem_ready = 1'b0; #1;
        check_val("rst_mid_pre_stage", 32'(stage), 32'd3);
        check_val("rst_mid_pre_we", 32'(DMem_WE), 32'd1);
        rst_n = 1'b0; #1;
        check_val("rst_mid_stage", 32'(stage), 32'd0);
        check_val("rst_mid_we", 32'(DMem_WE), 32'd0);
        check_val("rst_mid_addr", 32'(load_addr), 32'd0);
        check_val("rst_mid_vec", 32'(vec), 32'h041);
        @(negedge clk); #1;
        check_val("rst_hold_stage", 32'(stage), 32'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check_val("rst_rel_addr", 32'(load_addr), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
